// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master controller: FSM state encoding,
// frame geometry, field offsets and the frame-assembly helper.
package spi_pkg;

    localparam int FRAME_W  = 14;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 8;

    // Bit offsets of each field inside the LSB-first frame
    localparam int RW_POS   = 0;
    localparam int ADDR_POS = 1;
    localparam int DATA_POS = 6;

    localparam logic [3:0] LAST_BIT   = 4'(FRAME_W - 1);
    localparam logic [3:0] FIRST_DATA = 4'(DATA_POS);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Read frames carry zeros in the data field; the slave drives MISO there.
    function automatic logic [FRAME_W-1:0] build_frame(
        input logic              rw,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] wdata
    );
        logic [FRAME_W-1:0] f;
        f = '0;
        f[RW_POS] = rw;
        f[ADDR_POS +: ADDR_W] = addr;
        f[DATA_POS +: DATA_W] = rw ? wdata : '0;
        return f;
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// Half-period timer for the SPI master. Counts HALF clk cycles per phase
// while running; in the shift state it also alternates SCLK high/low phases
// and emits strobes for the SCLK rise, SCLK fall and end of each bit.
module spi_sclk_gen #(
    parameter int HALF = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    input  logic shift,
    output logic sclk,
    output logic half_end,
    output logic rise,
    output logic fall,
    output logic bit_end
);

    localparam logic [7:0] HALF_LAST = 8'(HALF - 1);

    logic [7:0] half_cnt_reg;
    logic       phase_reg;   // 0 = SCLK high half, 1 = SCLK low half

    // Half-period counter and SCLK phase; cleared on every FSM state entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            half_cnt_reg <= 8'd0;
            phase_reg    <= 1'b0;
        end else if (clr) begin
            half_cnt_reg <= 8'd0;
            phase_reg    <= 1'b0;
        end else if (run) begin
            if (half_cnt_reg == HALF_LAST) begin
                half_cnt_reg <= 8'd0;
                if (shift) begin
                    phase_reg <= ~phase_reg;
                end
            end else begin
                half_cnt_reg <= half_cnt_reg + 8'd1;
            end
        end
    end

    assign half_end = run && (half_cnt_reg == HALF_LAST);
    assign sclk     = shift && !phase_reg;
    // rise marks the first clk cycle with SCLK high; fall marks the last one
    assign rise     = sclk && (half_cnt_reg == 8'd0);
    assign fall     = sclk && half_end;
    assign bit_end  = shift && phase_reg && half_end;

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master issuing 14-bit LSB-first register frames
// (rw, addr[4:0], wdata[7:0]) and capturing 8 bits of read data.
// Optional feature macro: SPI_MASTER_BURST_EN -- when defined, a start in
// the DONE cycle chains straight into the next frame with CS held low.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int HALF = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              MISO,
    output logic              SCLK,
    output logic              MOSI,
    output logic              CS,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata
);

    state_t              state_reg;
    state_t              state_next;
    logic [FRAME_W-1:0]  shift_reg;
    logic [DATA_W-1:0]   rx_reg;
    logic [DATA_W-1:0]   rdata_reg;
    logic [3:0]          bit_cnt_reg;
    logic                rw_reg;

    logic accept;
    logic state_entry;
    logic gen_sclk;
    logic half_end;
    logic rise;
    logic fall;
    logic bit_end;

`ifdef SPI_MASTER_BURST_EN
    assign accept = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
`else
    assign accept = start && (state_reg == ST_IDLE);
`endif

    assign state_entry = (state_next != state_reg);

    spi_sclk_gen #(
        .HALF (HALF)
    ) u_sclk_gen (
        .clk      (clk),
        .rst      (rst),
        .clr      (state_entry),
        .run      ((state_reg == ST_SETUP) || (state_reg == ST_SHIFT) || (state_reg == ST_HOLD)),
        .shift    (state_reg == ST_SHIFT),
        .sclk     (gen_sclk),
        .half_end (half_end),
        .rise     (rise),
        .fall     (fall),
        .bit_end  (bit_end)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (accept) state_next = ST_SETUP;
            ST_SETUP: if (half_end) state_next = ST_SHIFT;
            ST_SHIFT: if (bit_end && (bit_cnt_reg == LAST_BIT)) state_next = ST_HOLD;
            ST_HOLD:  if (half_end) state_next = ST_DONE;
            ST_DONE:  state_next = accept ? ST_SETUP : ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // FSM outputs; MOSI is the low bit of the frame shifter while CS is low
    always_comb begin
        CS   = 1'b1;
        SCLK = 1'b0;
        MOSI = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        case (state_reg)
            ST_SETUP, ST_SHIFT, ST_HOLD: begin
                CS   = 1'b0;
                SCLK = gen_sclk;
                MOSI = shift_reg[0];
                busy = 1'b1;
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
`ifdef SPI_MASTER_BURST_EN
                CS   = !start;
`endif
            end
            default: ;
        endcase
    end

    // Bit counter: advances at each bit end, cleared on every state entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt_reg <= 4'd0;
        end else if (state_entry) begin
            bit_cnt_reg <= 4'd0;
        end else if (bit_end) begin
            bit_cnt_reg <= bit_cnt_reg + 4'd1;
        end
    end

    // Frame shifter: loaded on accept, advanced as SCLK falls so MOSI only
    // changes on falling transitions
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_reg <= '0;
            rw_reg    <= 1'b0;
        end else if (accept) begin
            shift_reg <= build_frame(rw, addr, wdata);
            rw_reg    <= rw;
        end else if (fall) begin
            shift_reg <= {1'b0, shift_reg[FRAME_W-1:1]};
        end
    end

    // MISO capture on SCLK rise for data bits; first data bit ends in rx[0]
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_reg <= '0;
        end else if (rise && (bit_cnt_reg >= FIRST_DATA)) begin
            rx_reg <= {MISO, rx_reg[DATA_W-1:1]};
        end
    end

    // Read data publishes on entry to DONE so it is valid with the done pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_reg <= '0;
        end else if ((state_reg == ST_HOLD) && (state_next == ST_DONE) && !rw_reg) begin
            rdata_reg <= rx_reg;
        end
    end

    assign rdata = rdata_reg;

endmodule
